iterative_normalizer: RTL

//  Multi-cycle leading-zero normalizer. The inverse companion of the ALU's left

---
 rtl/iterative_normalizer.sv | 106 ++++++++++
 1 files changed

// File: rtl/iterative_normalizer.sv
// Multi-cycle leading-zero normalizer: binary search for the left-shift that
// moves the first set bit to the MSB, one log2 stage per clock.
module iterative_normalizer #(
    parameter int N = 32,
    parameter int M = 5
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] in,
    output logic [N-1:0] out,
    output logic [M-1:0] count,
    output logic         zero,
    output logic         busy,
    output logic         ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [M-1:0] K_LAST = M'(M - 1);
    localparam logic [M-1:0] ONE_M  = M'(1);

    state_t       state_r;
    logic [N-1:0] work_r;
    logic [M-1:0] cnt_r;
    logic [M-1:0] k_r;

    logic [M-1:0] step_s;
    logic [N-1:0] hi_mask_s;
    logic [N-1:0] work_nxt_s;
    logic [M-1:0] cnt_nxt_s;
    logic         zero_nxt_s;

    // One search stage: shift by 2**k when the top 2**k bits are all clear.
    always_comb begin
        step_s     = ONE_M << k_r;
        hi_mask_s  = ~({N{1'b1}} >> step_s);
        work_nxt_s = work_r;
        cnt_nxt_s  = cnt_r;
        if ((work_r & hi_mask_s) == {N{1'b0}}) begin
            work_nxt_s = work_r << step_s;
            cnt_nxt_s  = cnt_r + step_s;
        end else begin
            work_nxt_s = work_r;
            cnt_nxt_s  = cnt_r;
        end
        zero_nxt_s = (work_nxt_s == {N{1'b0}});
    end

    // Control FSM, search datapath and registered result outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            work_r  <= {N{1'b0}};
            cnt_r   <= {M{1'b0}};
            k_r     <= {M{1'b0}};
            out     <= {N{1'b0}};
            count   <= {M{1'b0}};
            zero    <= 1'b0;
            busy    <= 1'b0;
            ready   <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    ready <= 1'b0;
                    if (start) begin
                        state_r <= RUN;
                        work_r  <= in;
                        cnt_r   <= {M{1'b0}};
                        k_r     <= K_LAST;
                        busy    <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                RUN: begin
                    work_r <= work_nxt_s;
                    cnt_r  <= cnt_nxt_s;
                    if (k_r == {M{1'b0}}) begin
                        state_r <= DONE;
                        busy    <= 1'b0;
                        ready   <= 1'b1;
                        out     <= work_nxt_s;
                        zero    <= zero_nxt_s;
                        // An all-zero operand walks every stage; its count is meaningless.
                        count   <= zero_nxt_s ? {M{1'b0}} : cnt_nxt_s;
                    end else begin
                        k_r   <= k_r - ONE_M;
                        ready <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

endmodule
